bikelight_mode_ctrl: RTL and testbench

Front-end controller that sequences the bike light from a single raw pushbutton. It does three things: synchronises and debounces the button, runs the mode state machine (OFF -> ON -> BLINK -> DIM -> OFF), and drives the LED with the mode-specific waveform (steady, blink timer or PWM dim). It sits between the board button pin and the light LED, and exposes the current mode for status/debug.

---
 rtl/bikelight_mode_ctrl.sv | 167 ++++++++++++++++
 tb/tb_bikelight_mode_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bikelight_mode_ctrl.sv
// Bike light front end: button sync/debounce, OFF->ON->BLINK->DIM mode FSM, LED waveform.
// Optional auto-off after an idle period when BIKELIGHT_AUTO_OFF_EN is defined.
module bikelight_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter int BLINK_HALF        = 8,
  parameter int PWM_BITS          = 4,
  parameter int DIM_DUTY          = 4,
  parameter int IDLE_TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [3:0] state,
  output logic       led,
  output logic       press_pulse
);

  typedef enum logic [3:0] {
    OFF   = 4'b0001,
    ON    = 4'b0010,
    BLINK = 4'b0100,
    DIM   = 4'b1000
  } mode_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || BLINK_HALF < 1 ||
        PWM_BITS < 1 || DIM_DUTY >= (1 << PWM_BITS) || IDLE_TIMEOUT < 1) begin : g_bad_params
      $error("bikelight_mode_ctrl: illegal parameter combination");
    end
  endgenerate

  logic           sync1, sync2;
  logic           db_level, db_prev;
  logic [DBW-1:0] db_cnt;
  logic [HW-1:0]  hold_cnt;
  logic           long_pulse;
  mode_t          mode, nxt;
  logic [BW-1:0]  blink_cnt;
  logic           blink_ph;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_nxt;

  assign state   = mode;
  assign pwm_nxt = pwm_cnt + PWM_BITS'(1);

  // Level flips after DEBOUNCE_CYCLES consecutive disagreeing samples; press_pulse is its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_level    <= 1'b0;
      db_prev     <= 1'b0;
      db_cnt      <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db_level;
      press_pulse <= db_level & ~db_prev;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  // Hold counter saturates, so long_pulse fires exactly once per hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= db_level && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
      if (!db_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HW'(LONG_PRESS_CYCLES)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

`ifdef BIKELIGHT_AUTO_OFF_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic          idle_fire;

  assign idle_fire = (idle_cnt == IW'(IDLE_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (press_pulse || (nxt != OFF && nxt != mode) || mode == OFF) begin
      idle_cnt <= '0;
    end else if (!idle_fire) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`endif

  always_comb begin
    nxt = mode;
    if (press_pulse) begin
      case (mode)
        OFF:     nxt = ON;
        ON:      nxt = BLINK;
        BLINK:   nxt = DIM;
        default: nxt = OFF;
      endcase
    end else if (long_pulse) begin
      nxt = OFF;
    end
`ifdef BIKELIGHT_AUTO_OFF_EN
    else if (idle_fire) begin
      nxt = OFF;
    end
`endif
  end

  // LED is computed from the next mode so state and led change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= OFF;
      led       <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      mode <= nxt;
      case (nxt)
        ON: led <= 1'b1;
        BLINK: begin
          if (mode != BLINK) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
            led       <= 1'b1;
          end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
            led       <= ~blink_ph;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
            led       <= blink_ph;
          end
        end
        DIM: begin
          if (mode != DIM) begin
            pwm_cnt <= '0;
            led     <= (PWM_BITS'(DIM_DUTY) != '0);
          end else begin
            pwm_cnt <= pwm_nxt;
            led     <= (pwm_nxt < PWM_BITS'(DIM_DUTY));
          end
        end
        default: led <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bikelight_mode_ctrl.sv
// Scoreboard bench: each driven press queues its expected pulse cycle and next mode.
module tb_bikelight_mode_ctrl;
  localparam int DEB  = 16;
  localparam int LONG = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [3:0] state;
  logic       led;
  logic       press_pulse;

  always #5 clk = ~clk;

  bikelight_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .BLINK_HALF(8),
    .PWM_BITS(4), .DIM_DUTY(4), .IDLE_TIMEOUT(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .state(state), .led(led), .press_pulse(press_pulse)
  );

  typedef struct {
    int       cyc;
    logic [3:0] st;
    bit       lng;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [3:0] m_state  = 4'b0001;
  int         m_ent    = 0;
  bit         pend     = 1'b0;
  logic [3:0] pend_st  = 4'b0001;
  int         long_at  = -1;
  logic [3:0] sb_state = 4'b0001;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] adv(input logic [3:0] s);
    case (s)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0100;
      4'b0100: return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic led_model(input logic [3:0] s, input int k);
    case (s)
      4'b0010: return 1'b1;
      4'b0100: return ((k / 8) % 2) == 0;
      4'b1000: return (k % 16) < 4;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: apply model transitions, compare every cycle, consume pulses from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_state = 4'b0001;
      pend    = 1'b0;
      long_at = -1;
    end else begin
      if (pend) begin
        m_state = pend_st;
        m_ent   = cyc;
        pend    = 1'b0;
      end
      if (cyc == long_at) begin
        m_state = 4'b0001;
        m_ent   = cyc;
        long_at = -1;
      end
    end
    check("state", 32'(state), 32'(m_state));
    check("led", 32'(led), 32'(led_model(m_state, cyc - m_ent)));
    if (press_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexp_pulse", 32'(press_pulse), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("pulse_cyc", cyc, e.cyc);
        pend    = 1'b1;
        pend_st = e.st;
        if (e.lng) long_at = cyc + LONG;
      end
    end
  end

  task automatic press(input int hold, input int gap, input bit lng);
    @(negedge clk);
    btn = 1'b1;
    sb_state = adv(sb_state);
    exp_q.push_back('{cyc + 3 + DEB, sb_state, lng});
    if (lng) sb_state = 4'b0001;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", 32'(press_pulse), 32'(0));
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    press(20, 100, 1'b0);

    repeat (5) begin
      btn = 1'b1;
      repeat (10) @(negedge clk);
      btn = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (30) @(negedge clk);

    repeat (4) press(20, 100, 1'b0);

    press(20, 100, 1'b0);
    press(100, 100, 1'b1);

    press(20, 100, 1'b0);
    press(20, 100, 1'b0);
    press(20, 30, 1'b0);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'(4'b0001));
    check("async_led", 32'(led), 32'(0));
    sb_state = 4'b0001;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    press(20, 100, 1'b0);

    check("pending_pulses", exp_q.size(), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
